gf180mcu_fd_sc_mcu9t5v0__nor_flt: RTL and testbench



---
 rtl/gf180mcu_fd_sc_mcu9t5v0__nor_flt.sv | 102 ++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__nor_flt.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nor_flt.sv
`default_nettype none
// ============================================================================
// Module : gf180mcu_fd_sc_mcu9t5v0__nor_flt
// Brief  : Registered multi-channel NOR with pipeline and stability filter.
// Rev    : 1.0  initial release
// ============================================================================
module gf180mcu_fd_sc_mcu9t5v0__nor_flt #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 1,
  parameter int STAGES   = 1,
  parameter int FILT     = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic [CHANNELS*WIDTH-1:0] A,
  output logic [CHANNELS-1:0]       ZN,
  output logic [CHANNELS-1:0]       CHG,
  output logic                      VLD
);

  localparam int            CW          = ($clog2(FILT + 1) < 1) ? 1 : $clog2(FILT + 1);
  localparam int            FW          = $clog2(STAGES + 2);
  localparam logic [CW-1:0] C_FILT      = CW'(FILT);
  localparam logic [FW-1:0] C_FILL_MAX  = FW'(STAGES + 1);
  localparam logic [FW-1:0] C_FILL_LAST = FW'(STAGES);

  logic [CHANNELS-1:0]              w_raw;
  logic [CHANNELS-1:0]              w_cand;
  logic [STAGES-1:0][CHANNELS-1:0]  r_pipe;
  logic [CHANNELS-1:0][CW-1:0]      r_cnt;
  logic [CHANNELS-1:0]              r_zn;
  logic [CHANNELS-1:0]              r_chg;
  logic [FW-1:0]                    r_fill;
  logic                             r_vld;

  genvar n;
  generate
    for (n = 0; n < CHANNELS; n++) begin : g_raw
      assign w_raw[n] = ~|A[n*WIDTH +: WIDTH];
    end
  endgenerate

  // Stages reset to 1, the NOR of an all-zero input group.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pipe <= '1;
    end else if (EN) begin
      r_pipe[0] <= w_raw;
      for (int k = 1; k < STAGES; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  assign w_cand = r_pipe[STAGES-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
      r_zn  <= '1;
      r_chg <= '0;
    end else if (!EN) begin
      r_chg <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_cand[c] == r_zn[c]) begin
          r_cnt[c] <= '0;
          r_chg[c] <= 1'b0;
        end else if (r_cnt[c] == C_FILT) begin
          r_zn[c]  <= w_cand[c];
          r_cnt[c] <= '0;
          r_chg[c] <= 1'b1;
        end else begin
          r_cnt[c] <= r_cnt[c] + CW'(1);
          r_chg[c] <= 1'b0;
        end
      end
    end
  end

  // VLD is registered alongside the fill counter so it needs no decode.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fill <= '0;
      r_vld  <= 1'b0;
    end else if (EN) begin
      if (r_fill != C_FILL_MAX) begin
        r_fill <= r_fill + FW'(1);
      end
      if (r_fill == C_FILL_LAST) begin
        r_vld <= 1'b1;
      end
    end
  end

  assign ZN  = r_zn;
  assign CHG = r_chg;
  assign VLD = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__nor_flt.sv
`default_nettype none
// ============================================================================
// Module : tb_gf180mcu_fd_sc_mcu9t5v0__nor_flt
// Brief  : Directed scoreboard bench over five parameterisations of the NOR filter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gf180mcu_fd_sc_mcu9t5v0__nor_flt;

  logic clk;
  logic rst, rst4;
  logic en0, en1, en2, en3, en4;
  logic [1:0]  a0, a1, a2, a4;
  logic [11:0] a3;
  logic        zn0, zn1, zn2, zn4, chg0, chg1, chg2, chg4;
  logic [3:0]  zn3, chg3;
  logic        vld0, vld1, vld2, vld3, vld4;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    int         inst;
    logic [3:0] zn;
    logic [3:0] chg;
    logic       vld;
  } exp_t;
  exp_t sb[$];

  gf180mcu_fd_sc_mcu9t5v0__nor_flt #(.WIDTH(2), .CHANNELS(1), .STAGES(2), .FILT(0)) u0 (
    .CLK(clk), .RST(rst), .EN(en0), .A(a0), .ZN(zn0), .CHG(chg0), .VLD(vld0));
  gf180mcu_fd_sc_mcu9t5v0__nor_flt #(.WIDTH(2), .CHANNELS(1), .STAGES(1), .FILT(3)) u1 (
    .CLK(clk), .RST(rst), .EN(en1), .A(a1), .ZN(zn1), .CHG(chg1), .VLD(vld1));
  gf180mcu_fd_sc_mcu9t5v0__nor_flt #(.WIDTH(2), .CHANNELS(1), .STAGES(1), .FILT(2)) u2 (
    .CLK(clk), .RST(rst), .EN(en2), .A(a2), .ZN(zn2), .CHG(chg2), .VLD(vld2));
  gf180mcu_fd_sc_mcu9t5v0__nor_flt #(.WIDTH(3), .CHANNELS(4), .STAGES(1), .FILT(0)) u3 (
    .CLK(clk), .RST(rst), .EN(en3), .A(a3), .ZN(zn3), .CHG(chg3), .VLD(vld3));
  gf180mcu_fd_sc_mcu9t5v0__nor_flt #(.WIDTH(2), .CHANNELS(1), .STAGES(1), .FILT(5)) u4 (
    .CLK(clk), .RST(rst4), .EN(en4), .A(a4), .ZN(zn4), .CHG(chg4), .VLD(vld4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] obs_zn(int i);
    case (i)
      0: return {3'b0, zn0};
      1: return {3'b0, zn1};
      2: return {3'b0, zn2};
      3: return zn3;
      default: return {3'b0, zn4};
    endcase
  endfunction

  function automatic logic [3:0] obs_chg(int i);
    case (i)
      0: return {3'b0, chg0};
      1: return {3'b0, chg1};
      2: return {3'b0, chg2};
      3: return chg3;
      default: return {3'b0, chg4};
    endcase
  endfunction

  function automatic logic obs_vld(int i);
    case (i)
      0: return vld0;
      1: return vld1;
      2: return vld2;
      3: return vld3;
      default: return vld4;
    endcase
  endfunction

  task automatic push(string tag, int inst, logic [3:0] zn, logic [3:0] chg, logic vld);
    exp_t e;
    e.tag = tag; e.inst = inst; e.zn = zn; e.chg = chg; e.vld = vld;
    sb.push_back(e);
  endtask

  task automatic chk(string tag, logic [3:0] o, logic [3:0] x);
    checks++;
    assert (o === x) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, x);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".zn"},  obs_zn(e.inst),  e.zn);
      chk({e.tag, ".chg"}, obs_chg(e.inst), e.chg);
      chk({e.tag, ".vld"}, {3'b0, obs_vld(e.inst)}, {3'b0, e.vld});
    end
  endtask

  // Sample 1 time unit after the rising edge, then compare pending expectations.
  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    rst = 1'b1; rst4 = 1'b1;
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1; en3 = 1'b1; en4 = 1'b1;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0; a4 = '0;
    #3;
    push("reset_u0", 0, 4'h1, 4'h0, 1'b0);
    push("reset_u3", 3, 4'hF, 4'h0, 1'b0);
    drain();
    rst = 1'b0; rst4 = 1'b0;

    // Fill: STAGES=2 so VLD rises after the third enabled edge.
    for (int i = 1; i <= 4; i++) begin
      push($sformatf("fill_e%0d", i), 0, 4'h1, 4'h0, (i >= 3));
      tick();
    end

    // Latency STAGES=2, FILT=0: capture edge plus two more.
    a0 = 2'b01;
    push("lat_fall_e0", 0, 4'h1, 4'h0, 1'b1); tick();
    push("lat_fall_e1", 0, 4'h1, 4'h0, 1'b1); tick();
    push("lat_fall_e2", 0, 4'h0, 4'h1, 1'b1); tick();
    a0 = 2'b00;
    push("lat_rise_e0", 0, 4'h0, 4'h0, 1'b1); tick();
    push("lat_rise_e1", 0, 4'h0, 4'h0, 1'b1); tick();
    push("lat_rise_e2", 0, 4'h1, 4'h1, 1'b1); tick();
    push("lat_rise_e3", 0, 4'h1, 4'h0, 1'b1); tick();

    // Glitch rejection STAGES=1, FILT=3: three-cycle pulse is swallowed.
    a1 = 2'b01;
    for (int i = 0; i < 3; i++) begin
      push($sformatf("glitch_hi%0d", i), 1, 4'h1, 4'h0, 1'b1); tick();
    end
    a1 = 2'b00;
    for (int i = 0; i < 3; i++) begin
      push($sformatf("glitch_lo%0d", i), 1, 4'h1, 4'h0, 1'b1); tick();
    end
    a1 = 2'b01;
    for (int i = 0; i < 4; i++) begin
      push($sformatf("persist_e%0d", i), 1, 4'h1, 4'h0, 1'b1); tick();
    end
    push("persist_e4", 1, 4'h0, 4'h1, 1'b1); tick();
    push("persist_e5", 1, 4'h0, 4'h0, 1'b1); tick();

    // Enable stall STAGES=1, FILT=2: needs four enabled edges in total.
    a2 = 2'b01;
    en2 = 1'b1; push("stall_e1", 2, 4'h1, 4'h0, 1'b1); tick();
    en2 = 1'b0; push("stall_e2", 2, 4'h1, 4'h0, 1'b1); tick();
    en2 = 1'b0; push("stall_e3", 2, 4'h1, 4'h0, 1'b1); tick();
    en2 = 1'b1; push("stall_e4", 2, 4'h1, 4'h0, 1'b1); tick();
    en2 = 1'b1; push("stall_e5", 2, 4'h1, 4'h0, 1'b1); tick();
    en2 = 1'b1; push("stall_e6", 2, 4'h0, 4'h1, 1'b1); tick();
    en2 = 1'b0; push("stall_chg_clr", 2, 4'h0, 4'h0, 1'b1); tick();

    // Multi-channel: 12'h0F0 clears channels 1 and 2 only.
    a3 = 12'h0F0;
    push("multi_e0", 3, 4'hF, 4'h0, 1'b1); tick();
    push("multi_e1", 3, 4'h9, 4'h6, 1'b1); tick();
    a3 = 12'h000;
    push("multi_e2", 3, 4'h9, 4'h0, 1'b1); tick();
    push("multi_e3", 3, 4'hF, 4'h6, 1'b1); tick();
    push("multi_e4", 3, 4'hF, 4'h0, 1'b1); tick();

    // Async reset mid-count at cnt=3 with FILT=5.
    a4 = 2'b01;
    for (int i = 0; i < 4; i++) begin
      push($sformatf("arst_pre%0d", i), 4, 4'h1, 4'h0, 1'b1); tick();
    end
    #2;
    rst4 = 1'b1;
    #1;
    push("arst_now", 4, 4'h1, 4'h0, 1'b0);
    drain();
    rst4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push($sformatf("arst_post%0d", i), 4, 4'h1, 4'h0, (i >= 1)); tick();
    end
    push("arst_post6", 4, 4'h0, 4'h1, 1'b1); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
